// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code constants and types shared by the K=7 encoder and the Viterbi decoder
package viterbi_pkg;
  localparam int K = 7;
  localparam int STATE_W = K - 1;
  localparam logic [K-1:0] G0_OCT = 7'o171;
  localparam logic [K-1:0] G1_OCT = 7'o133;
  localparam int TAIL_CNT_W = $clog2(STATE_W);
  localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(STATE_W - 1);
  typedef logic [1:0] pair_t;
  typedef enum logic {RUN, FLUSH} enc_state_e;
  // Window MSB is the current bit, followed by sr[0] (newest) down to sr[STATE_W-1] (oldest)
  function automatic logic [K-1:0] enc_window(input logic cur_bit, input logic [STATE_W-1:0] sr);
    logic [K-1:0] w;
    w[K-1] = cur_bit;
    for (int i = 0; i < STATE_W; i++) w[STATE_W-1-i] = sr[i];
    return w;
  endfunction
endpackage

// File: rtl/conv_parity.sv
// conv_parity: parity of one K-bit encoder window against a generator mask
module conv_parity
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] GEN = G0_OCT
) (
  input  logic [K-1:0] win,
  output logic         parity
);
  assign parity = ^(win & GEN);
endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 K=7 convolutional encoder with valid/ready handshakes on both sides
// ENC_ZERO_TAIL_EN: terminate every frame with K-1 zero tail pairs instead of clearing the state
module conv_encoder_k7
  import viterbi_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  logic  in_bit,
  input  logic  in_last,
  output logic  out_valid,
  input  logic  out_ready,
  output pair_t out_pair,
  output logic  out_last,
  output logic  busy
);
  logic [STATE_W-1:0] sr;
  logic [K-1:0] win;
  logic advance, accept, cur_bit, emit, emit_last, clear_sr, p0, p1;
  assign advance = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
`ifdef ENC_ZERO_TAIL_EN
  enc_state_e state;
  logic [TAIL_CNT_W-1:0] tail_cnt;
  logic flushing;
  assign flushing = state == FLUSH;
  assign in_ready = advance && !flushing;
  assign emit = accept || (advance && flushing);
  assign emit_last = flushing && tail_cnt == TAIL_LAST;
  assign clear_sr = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      tail_cnt <= '0;
    end else if (advance && flushing) begin
      state <= emit_last ? RUN : FLUSH;
      tail_cnt <= emit_last ? '0 : tail_cnt + 1'b1;
    end else if (accept && in_last) begin
      state <= FLUSH;
      tail_cnt <= '0;
    end
`else
  assign in_ready = advance;
  assign emit = accept;
  assign emit_last = accept && in_last;
  assign clear_sr = emit_last;
`endif
  // Tail advances shift in zeros because no bit is accepted while flushing
  assign cur_bit = accept && in_bit;
  assign win = enc_window(cur_bit, sr);
  conv_parity #(.GEN(G0_OCT)) u_p0 (.win(win), .parity(p0));
  conv_parity #(.GEN(G1_OCT)) u_p1 (.win(win), .parity(p1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      out_valid <= 1'b0;
      out_pair <= '0;
      out_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= emit;
        out_last <= emit_last;
        if (emit) begin
          out_pair <= {p1, p0};
          sr <= clear_sr ? '0 : {sr[STATE_W-2:0], cur_bit};
        end
      end
      if (accept) busy <= 1'b1;
      else if (out_valid && out_ready && out_last) busy <= 1'b0;
    end
endmodule

// File: tb/tb_conv_encoder_k7.sv
// tb_conv_encoder_k7: directed and randomized self-checking bench for conv_encoder_k7
module tb_conv_encoder_k7;
`ifdef ENC_ZERO_TAIL_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy;
  logic [1:0] out_pair;
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  logic [2:0] exp_q[$];
  logic [5:0] m_sr = '0;
  bit use_model = 1'b0, hold = 1'b0;
  logic [2:0] held = '0;
  logic [7:0] v5a = 8'h5A;
  logic [1:0] imp[7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
  logic [1:0] t101[9] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};

  conv_encoder_k7 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Taps written as delays: G0=171 -> d0,d1,d2,d3,d6; G1=133 -> d0,d2,d3,d5,d6
  function automatic logic [1:0] ref_pair(input logic b, input logic [5:0] s);
    return {b ^ s[1] ^ s[2] ^ s[4] ^ s[5], b ^ s[0] ^ s[1] ^ s[2] ^ s[5]};
  endfunction

  task automatic model_push(input logic b, input logic l);
    exp_q.push_back({l && !TAIL, ref_pair(b, m_sr)});
    m_sr = {m_sr[4:0], b};
    if (l) begin
      for (int i = 0; i < 6; i++)
        if (TAIL) begin
          exp_q.push_back({i == 5, ref_pair(1'b0, m_sr)});
          m_sr = {m_sr[4:0], 1'b0};
        end
      m_sr = '0;
    end
  endtask

  task automatic push_impulse();
    for (int i = 0; i < (TAIL ? 7 : 1); i++) exp_q.push_back({i == (TAIL ? 6 : 0), imp[i]});
  endtask

  task automatic step(input logic ordy, input logic iv, input logic ib, input logic il, output logic acc);
    logic [2:0] e;
    @(negedge clk);
    if (hold) check("hold", {out_valid, out_last, out_pair}, {1'b1, held});
    out_ready = ordy;
    in_valid = iv;
    in_bit = ib;
    in_last = il;
    #1;
    hold = out_valid && !out_ready;
    held = {out_last, out_pair};
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      check("pending", exp_q.size() != 0, 1);
      e = 3'b000;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("pair", {out_last, out_pair}, e);
    end
    if (acc && use_model) model_push(in_bit, in_last);
  endtask

  task automatic send(input logic b, input logic l, input bit rnd);
    logic acc, iv, ordy;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      iv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(ordy, iv, b, l, acc);
    end
    if (acc) acc_cyc = cyc;
    else check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    check("drain", exp_q.size(), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic acc;
    int c1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_pair", out_pair, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_impulse();
    send(1'b1, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < (TAIL ? 22 : 16); i++) exp_q.push_back({i == (TAIL ? 21 : 15), 2'b00});
    for (int i = 0; i < 16; i++) begin
      send(1'b0, i == 15, 1'b0);
      if (i == 1) check("busy_mid", busy, 1);
    end
    drain();
    for (int i = 0; i < (TAIL ? 9 : 3); i++) exp_q.push_back({i == (TAIL ? 8 : 2), t101[i]});
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    drain();
    push_impulse();
    send(1'b1, 1'b1, 1'b0);
    drain();
    use_model = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b1, i == 7, 1'b0);
    c1 = acc_cyc;
    for (int i = 0; i < 8; i++) begin
      send(v5a[7-i], i == 7, 1'b0);
      if (i == 0) check("b2b_gap", acc_cyc - c1, TAIL ? 7 : 1);
    end
    drain();
    for (int i = 0; i < 1000; i++) send(1'($urandom_range(0, 1)), i == 999, 1'b1);
    drain();
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    if (TAIL) begin
      send(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    end
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_last", out_last, 0);
    exp_q.delete();
    m_sr = '0;
    hold = 1'b0;
    in_valid = 1'b0;
    use_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_impulse();
    send(1'b1, 1'b1, 1'b0);
    drain();
    check("leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
